// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Purpose: main control unit of a multicycle MIPS-style datapath. It is a
// Moore FSM, so every control output is decoded from the registered state
// alone. Op is sampled only while leaving DECODE and MEMADR.
//
// Configuration macro: MC_JUMP_EN
//   defined   : opcode 000010 runs through the JUMP state (PCSrc=10).
//   undefined : there is no JUMP state logic, opcode 000010 is treated as
//               illegal, and PCSrc=10 is never driven.
//
// Ports:
//   clk        in   1  clock; all state updates on the rising edge
//   reset      in   1  synchronous, active-high; forces FETCH
//   Op         in   6  opcode field of the instruction register
//   state      out  4  current FSM state (debug)
//   illegal_op out  1  high only in ILLEGAL
//   IorD       out  1  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite   out  1  memory write strobe
//   IRWrite    out  1  instruction register load
//   RegDst     out  1  destination register select (0 = rt, 1 = rd)
//   MemtoReg   out  1  write-back data select (0 = ALUOut, 1 = memory)
//   RegWrite   out  1  register file write enable
//   ALUSrcA    out  1  ALU A select (0 = PC, 1 = A register)
//   ALUSrcB    out  2  ALU B select (00 = B, 01 = 1, 10 = sign-ext imm)
//   ALUOp      out  2  ALU class (00 = add, 01 = sub, 10 = funct)
//   PCSrc      out  2  next-PC select (00 = ALU, 01 = ALUOut, 10 = jump)
//   PCWrite    out  1  unconditional PC load
//   Branch     out  1  conditional PC load (qualified by Zero outside)
//
// There is no handshake: the FSM advances on every clock edge.
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Branch
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    ILLEGAL  = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_n;

  // State register; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_n;
  end

  assign state = state_q;

  // Next-state logic. Encodings 13-15 (and 11 when the jump state is not
  // built) fall through to FETCH via the default arm.
  always_comb begin
    state_n = FETCH;
    case (state_q)
      FETCH:  state_n = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = EXECUTE;
          OP_BEQ:       state_n = BRANCH;
          OP_ADDI:      state_n = ADDIEXEC;
`ifdef MC_JUMP_EN
          OP_J:         state_n = JUMP;
`endif
          default:      state_n = ILLEGAL;
        endcase
      end
      MEMADR:   state_n = (Op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    state_n = MEMWB;
      MEMWB:    state_n = FETCH;
      MEMWR:    state_n = FETCH;
      EXECUTE:  state_n = ALUWB;
      ALUWB:    state_n = FETCH;
      BRANCH:   state_n = FETCH;
      ADDIEXEC: state_n = ADDIWB;
      ADDIWB:   state_n = FETCH;
`ifdef MC_JUMP_EN
      JUMP:     state_n = FETCH;
`endif
      ILLEGAL:  state_n = FETCH;
      default:  state_n = FETCH;
    endcase
  end

  // Output decode: everything defaults to 0, each state raises only its own
  // controls. ALUSrcB=11 appears in no arm, so it can never be driven.
  always_comb begin
    illegal_op = 1'b0;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      DECODE: begin
        // Precompute the branch target into ALUOut.
        ALUSrcB = 2'b10;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: RegWrite = 1'b1;
`ifdef MC_JUMP_EN
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
`endif
      ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control: per-instruction state sequences
// with the full control vector checked every cycle, reset behaviour, then a
// random-opcode run tracked by a small reference next-state function.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [3:0] state;
  logic       illegal_op, IorD, MemWrite, IRWrite, RegDst, MemtoReg;
  logic       RegWrite, ALUSrcA, PCWrite, Branch;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;

  int tests;
  int fails;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .state      (state),
    .illegal_op (illegal_op),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSrc      (PCSrc),
    .PCWrite    (PCWrite),
    .Branch     (Branch)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] ctrl;
  assign ctrl = {illegal_op, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, Branch};

  function automatic logic [15:0] mk(
    input logic ill, input logic iord, input logic mw, input logic irw,
    input logic rd, input logic m2r, input logic rw, input logic srca,
    input logic [1:0] srcb, input logic [1:0] aluop, input logic [1:0] pcsrc,
    input logic pcw, input logic br);
    mk = {ill, iord, mw, irw, rd, m2r, rw, srca, srcb, aluop, pcsrc, pcw, br};
  endfunction

  // Expected control vector per state, written from the output table.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] s);
    case (s)
      4'd0:  exp_ctrl = mk(0,0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0);
      4'd1:  exp_ctrl = mk(0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00,0,0);
      4'd2:  exp_ctrl = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
      4'd3:  exp_ctrl = mk(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
      4'd4:  exp_ctrl = mk(0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0);
      4'd5:  exp_ctrl = mk(0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
      4'd6:  exp_ctrl = mk(0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
      4'd7:  exp_ctrl = mk(0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0);
      4'd8:  exp_ctrl = mk(0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,1);
      4'd9:  exp_ctrl = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
      4'd10: exp_ctrl = mk(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0);
`ifdef MC_JUMP_EN
      4'd11: exp_ctrl = mk(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
`endif
      4'd12: exp_ctrl = mk(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
      default: exp_ctrl = 16'h0000;
    endcase
  endfunction

  // Reference next state from the transition list.
  function automatic logic [3:0] next_st(input logic [3:0] s, input logic [5:0] op);
    next_st = 4'd0;
    case (s)
      4'd0: next_st = 4'd1;
      4'd1: begin
        if (op == 6'b100011 || op == 6'b101011) next_st = 4'd2;
        else if (op == 6'b000000) next_st = 4'd6;
        else if (op == 6'b000100) next_st = 4'd8;
        else if (op == 6'b001000) next_st = 4'd9;
`ifdef MC_JUMP_EN
        else if (op == 6'b000010) next_st = 4'd11;
`endif
        else next_st = 4'd12;
      end
      4'd2: next_st = (op == 6'b100011) ? 4'd3 : 4'd5;
      4'd3: next_st = 4'd4;
      4'd6: next_st = 4'd7;
      4'd9: next_st = 4'd10;
      default: next_st = 4'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH. seq holds the expected state codes as
  // nibbles, seq[3:0] first. Op carries the opcode only in DECODE/MEMADR and
  // random junk elsewhere, which must not affect the sequence.
  task automatic run_instr(input string tag, input logic [5:0] op,
                           input int n, input logic [31:0] seq);
    for (int i = 0; i < n; i++) begin
      logic [3:0] es;
      es = seq[i*4 +: 4];
      chk($sformatf("%s/c%0d/state", tag, i), {12'd0, state}, {12'd0, es});
      chk($sformatf("%s/c%0d/ctrl", tag, i), ctrl, exp_ctrl(es));
      if (i == 1 || i == 2) Op = op;
      else                  Op = 6'($urandom_range(0, 63));
      step();
    end
  endtask

  initial begin
    logic [3:0] exp_s;
    logic [3:0] exp_nx;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    Op    = 6'b111111;

    // Reset pulse
    step();
    step();
    chk("reset/state", {12'd0, state}, 16'd0);
    chk("reset/ctrl", ctrl, exp_ctrl(4'd0));
    reset = 1'b0;

    run_instr("lw",   6'b100011, 5, 32'h0004_3210);
    run_instr("sw",   6'b101011, 4, 32'h0000_5210);
    run_instr("rtype", 6'b000000, 4, 32'h0000_7610);
    run_instr("addi", 6'b001000, 4, 32'h0000_A910);
    run_instr("beq",  6'b000100, 3, 32'h0000_0810);
    run_instr("illegal", 6'b111111, 3, 32'h0000_0C10);
`ifdef MC_JUMP_EN
    run_instr("j",    6'b000010, 3, 32'h0000_0B10);
`else
    run_instr("j",    6'b000010, 3, 32'h0000_0C10);
`endif
    chk("after_seq/state", {12'd0, state}, 16'd0);

    // Reset asserted while in MEMRD: back to FETCH, no MEMWB afterwards.
    run_instr("lw_rst", 6'b100011, 3, 32'h0000_0210);
    chk("rst_mid/memrd", {12'd0, state}, 16'd3);
    reset = 1'b1;
    Op    = 6'b100011;
    step();
    chk("rst_mid/state", {12'd0, state}, 16'd0);
    chk("rst_mid/ctrl", ctrl, exp_ctrl(4'd0));
    // Held reset keeps FETCH.
    step();
    step();
    chk("rst_hold/state", {12'd0, state}, 16'd0);
    reset = 1'b0;
    step();
    chk("rst_rel/state", {12'd0, state}, 16'd1);
    chk("rst_rel/ctrl", ctrl, exp_ctrl(4'd1));

    // Random-opcode run against the reference transition function.
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_s = 4'd0;
    for (int c = 0; c < 10000; c++) begin
      case ($urandom_range(0, 7))
        0: Op = 6'b100011;
        1: Op = 6'b101011;
        2: Op = 6'b000000;
        3: Op = 6'b000100;
        4: Op = 6'b001000;
        5: Op = 6'b000010;
        default: Op = 6'($urandom_range(0, 63));
      endcase
      exp_nx = next_st(exp_s, Op);
      step();
      exp_s = exp_nx;
      chk("rand/state", {12'd0, state}, {12'd0, exp_s});
      chk("rand/ctrl", ctrl, exp_ctrl(exp_s));
      tests++;
      assert (ALUSrcB !== 2'b11) else begin
        fails++;
        $error("FAIL rand/alusrcb: observed %b expected not 11", ALUSrcB);
      end
`ifndef MC_JUMP_EN
      tests++;
      assert (PCSrc !== 2'b10) else begin
        fails++;
        $error("FAIL rand/pcsrc: observed %b expected not 10", PCSrc);
      end
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL: Op  in  6  opcode field of the instruction register, valid from DECODE onward.
REQ-004 SHALL: state  out  4  current FSM state, for debug.
REQ-005 SHALL: illegal_op  out  1  high only in state ILLEGAL.
REQ-006 SHALL: IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-007 SHALL: MemWrite  out  1  memory write strobe.
REQ-008 SHALL: IRWrite  out  1  instruction register load.
REQ-009 SHALL: RegDst  out  1  destination register select: 0 = rt, 1 = rd.
REQ-010 SHALL: MemtoReg  out  1  write-back data select: 0 = ALUOut, 1 = memory data.
REQ-011 SHALL: RegWrite  out  1  register file write enable.
REQ-012 SHALL: ALUSrcA  out  1  ALU operand A select: 0 = PC, 1 = A register.
REQ-013 SHALL: ALUSrcB  out  2  operand-B mux select: 00 = B register, 01 = constant 1, 10 = sign-extended immediate; 11 SHALL never be driven.
REQ-014 SHALL: ALUOp  out  2  ALU operation class: 00 = add, 01 = subtract, 10 = decode funct field.
REQ-015 SHALL: PCSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-016 SHALL: PCWrite  out  1  unconditional PC load.
REQ-017 SHALL: Branch  out  1  conditional PC load; the datapath qualifies it with Zero.

Function
REQ-018 SHALL: Moore FSM; all outputs are decoded from the registered state only, and every output not listed for a state is 0.
REQ-019 SHALL: state encodings are FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, ILLEGAL=12; codes 13-15 SHALL transition to FETCH.
REQ-020 SHALL: FETCH drives IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1, then goes to DECODE.
REQ-021 SHALL: DECODE drives ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target), samples Op, and branches as follows:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 001000 -> ADDIEXEC
  - 000010 -> JUMP
  - any other opcode -> ILLEGAL
REQ-022 SHALL: MEMADR drives ALUSrcA=1, ALUSrcB=10, ALUOp=00; it goes to MEMRD if Op=100011, else MEMWR.
REQ-023 SHALL: MEMRD drives IorD=1 and goes to MEMWB; MEMWB drives RegDst=0, MemtoReg=1, RegWrite=1 and goes to FETCH.
REQ-024 SHALL: MEMWR drives IorD=1, MemWrite=1 and goes to FETCH.
REQ-025 SHALL: EXECUTE drives ALUSrcA=1, ALUSrcB=00, ALUOp=10 and goes to ALUWB; ALUWB drives RegDst=1, MemtoReg=0, RegWrite=1 and goes to FETCH.
REQ-026 SHALL: BRANCH drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 and goes to FETCH.
REQ-027 SHALL: ADDIEXEC drives ALUSrcA=1, ALUSrcB=10, ALUOp=00 and goes to ADDIWB; ADDIWB drives RegDst=0, MemtoReg=0, RegWrite=1 and goes to FETCH.
REQ-028 SHALL: JUMP drives PCSrc=10, PCWrite=1 and goes to FETCH.
REQ-029 SHALL: ILLEGAL drives illegal_op=1 for exactly one cycle and goes to FETCH; it writes no register, memory or PC.
REQ-030 SHALL: instruction latencies in cycles, counted from FETCH entry, are lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 3.
REQ-031 SHALL: Op changes outside DECODE and MEMADR have no effect on transitions.

Reset
REQ-032 SHALL: reset high at a rising edge forces state=FETCH, overriding any transition, from any state including mid-instruction; outputs then equal FETCH values on the following cycle.
REQ-033 SHALL: while reset is held high, the state remains FETCH; the first instruction fetch occurs on the first edge with reset low.

Configuration
REQ-034 SHALL: with macro MC_JUMP_EN defined, opcode 000010 goes DECODE -> JUMP as specified.
REQ-035 SHALL: without MC_JUMP_EN, the JUMP state is not built, opcode 000010 goes to ILLEGAL, and PCSrc=10 is never driven.

Verification
REQ-036 SHALL: reset pulse, then Op=100011 -> states 0,1,2,3,4,0; MEMWB shows RegWrite=1, MemtoReg=1; ALUSrcB sequence 01,10,10.
REQ-037 SHALL: Op=101011 -> states 0,1,2,5,0; MemWrite=1 only in MEMWR; RegWrite stays 0.
REQ-038 SHALL: Op=000000, then 001000 back to back -> 0,1,6,7,0,1,9,10,0; ALUOp=10 only in EXECUTE; RegDst=1 in ALUWB and 0 in ADDIWB.
REQ-039 SHALL: Op=000100 -> 0,1,8,0 with Branch=1, PCSrc=01, ALUOp=01 in BRANCH; Op=111111 -> 0,1,12,0 with illegal_op=1 for one cycle.
REQ-040 SHALL: reset asserted in MEMRD -> next state is FETCH and no MEMWB cycle follows; ALUSrcB never equals 11 over a 10,000-cycle random-opcode run, for both MC_JUMP_EN builds.
